// File: rtl/watch_pkg.sv
// Shared definitions for the watch time bus: field layout, line length,
// ASCII constants and the UART line-sender state encoding.
package watch_pkg;

  localparam int TIME_W = 24;
  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;
  localparam int MSEC_W = 7;

  // Field LSB positions inside {hour, min, sec, msec}
  localparam int MSEC_LSB = 0;
  localparam int SEC_LSB  = MSEC_LSB + MSEC_W;
  localparam int MIN_LSB  = SEC_LSB + SEC_W;
  localparam int HOUR_LSB = MIN_LSB + MIN_W;

  localparam int LINE_LEN = 13;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } tx_state_t;

endpackage

// File: rtl/watch_time_uart_tx_bin2ascii2.sv
// Combinational 7-bit binary to two ASCII decimal digits, saturating at 99.
module bin2ascii2
  import watch_pkg::*;
(
  input  logic [6:0] bin,
  output logic [7:0] tens,
  output logic [7:0] units
);

  logic [6:0] sat;
  logic [6:0] t_val;
  logic [6:0] u_val;

  always_comb begin
    sat   = (bin > 7'd99) ? 7'd99 : bin;
    t_val = sat / 7'd10;
    u_val = sat - 7'(t_val * 7'd10);
    tens  = ASCII_0 + {1'b0, t_val};
    units = ASCII_0 + {1'b0, u_val};
  end

endmodule

// File: rtl/watch_time_uart_tx.sv
// Sends a latched snapshot of the time bus as "HH:MM:SS.CC\r\n" into the TX FIFO.
// Optional WATCH_TX_PERIODIC_EN: also start a line whenever the seconds field changes.
//
// Handshake: a byte is transferred in every cycle where tx_push=1; tx_push is
// asserted combinationally only when in SEND and tx_full=0, so a full FIFO
// stalls the line with tx_data held until the push is accepted.
module watch_time_uart_tx
  import watch_pkg::*;
#(
  parameter logic [7:0] SEP_HMS = 8'h3A,
  parameter logic [7:0] SEP_CS  = 8'h2E
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TIME_W-1:0] i_time,
  input  logic              start,
  input  logic              tx_full,
  output logic              tx_push,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state,
  output logic [3:0]        dbg_idx
);

  tx_state_t         state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [TIME_W-1:0] snap_q, snap_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              req;
  logic              accept;
  logic              push;

  logic [6:0]        fld;
  logic [7:0]        dig_tens;
  logic [7:0]        dig_units;

`ifdef WATCH_TX_PERIODIC_EN
  logic [SEC_W-1:0]  prev_sec_q;
  logic              pend_q, pend_d;
  logic              trig;

  assign trig = (i_time[SEC_LSB +: SEC_W] != prev_sec_q);
  // start, trigger and a pending request collapse into one request
  assign req  = start | trig | pend_q;

  always_comb begin
    pend_d = pend_q;
    if (accept)
      pend_d = 1'b0;
    else if (trig && (state_q != IDLE))
      pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_sec_q <= '0;
      pend_q     <= 1'b0;
    end else begin
      prev_sec_q <= i_time[SEC_LSB +: SEC_W];
      pend_q     <= pend_d;
    end
  end
`else
  assign req = start;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    accept  = 1'b0;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          accept  = 1'b1;
          snap_d  = i_time;
          idx_d   = 4'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (!tx_full) begin
          push = 1'b1;
          if (idx_q == 4'(LINE_LEN - 1))
            state_d = DONE;
          else
            idx_d = idx_q + 4'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Field mux looks at the next index so tx_data is registered ahead of its push
  always_comb begin
    fld = 7'd0;
    case (idx_d)
      4'd0, 4'd1:  fld = {2'b00, snap_d[HOUR_LSB +: HOUR_W]};
      4'd3, 4'd4:  fld = {1'b0,  snap_d[MIN_LSB  +: MIN_W]};
      4'd6, 4'd7:  fld = {1'b0,  snap_d[SEC_LSB  +: SEC_W]};
      4'd9, 4'd10: fld = snap_d[MSEC_LSB +: MSEC_W];
      default:     fld = 7'd0;
    endcase
  end

  bin2ascii2 u_bin2ascii2 (
    .bin   (fld),
    .tens  (dig_tens),
    .units (dig_units)
  );

  always_comb begin
    tx_data_d = 8'h00;
    if (state_d == SEND) begin
      case (idx_d)
        4'd0, 4'd3, 4'd6, 4'd9:  tx_data_d = dig_tens;
        4'd1, 4'd4, 4'd7, 4'd10: tx_data_d = dig_units;
        4'd2, 4'd5:              tx_data_d = SEP_HMS;
        4'd8:                    tx_data_d = SEP_CS;
        4'd11:                   tx_data_d = ASCII_CR;
        4'd12:                   tx_data_d = ASCII_LF;
        default:                 tx_data_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= 4'd0;
      snap_q    <= '0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign tx_push   = push;
  assign tx_data   = tx_data_q;
  assign busy      = (state_q == SEND);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;
  assign dbg_idx   = idx_q;

endmodule

// File: doc/watch_time_uart_tx.md
# watch_time_uart_tx

Serializes a snapshot of the watch/stopwatch 24-bit time bus into the 13-byte ASCII line "HH:MM:SS.CC\r\n". It pushes the bytes one at a time into the UART TX FIFO. It sits between the mode mux output (the same bus that feeds the FND controller) and the TX FIFO write port, so the displayed time can be read out over UART.

## Interface
- SEP_HMS, default 8'h3A (':'), separator after HH and MM
- SEP_CS, default 8'h2E ('.'), separator before centiseconds
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i_time  in  24  {hour[4:0], min[5:0], sec[5:0], msec[6:0]}; msec in centiseconds
- start  in  1  one-cycle request to send one line
- tx_full  in  1  TX FIFO full; push is blocked while high
- tx_push  out  1  FIFO write strobe, one cycle per byte
- tx_data  out  8  ASCII byte, valid when tx_push=1
- busy  out  1  line transmission in progress
- done  out  1  one-cycle pulse after the last byte is pushed

## Operation
- States:
  - IDLE: busy=0. start=1 latches i_time into the snapshot register, clears byte index idx to 0 and moves to SEND.
  - SEND: busy=1. Each cycle with tx_full=0: tx_push=1, tx_data=byte[idx], idx++. With tx_full=1: tx_push=0, idx held. After the push with idx=12 the FSM moves to DONE.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- Byte order, idx 0..12: H1 H0 SEP_HMS M1 M0 SEP_HMS S1 S0 SEP_CS C1 C0 8'h0D 8'h0A.
- Digits are decimal tens/units of each field plus 8'h30. The msec field saturates to 99 when its 7-bit value exceeds 99. hour (≤31), min and sec (≤63) need no clamp.
- Snapshot coherency: i_time changes after the latch are ignored until the next line.
- start is ignored in SEND and DONE. No queueing in the base configuration.
- Reset values: tx_push=0, tx_data=8'h00, busy=0, done=0, idx=0, snapshot=0, state=IDLE.
- rst mid-line aborts the line. No further bytes are pushed, a partial line is left in the FIFO, and no done pulse is issued.

## Timing
- start sampled high at edge N (IDLE): busy=1 from cycle N+1. The first tx_push can occur in cycle N+1.
- With no backpressure, 13 pushes occur in cycles N+1..N+13, done in N+14, and start is accepted again from N+14's edge onward.
- Backpressure: tx_push is never asserted while tx_full=1 in the same cycle. tx_full is treated as combinational-ready, with no skid.
- tx_data is registered and stable while tx_push=1. Total latency from start to done is 14 + (cycles with tx_full=1 during SEND).

## Configuration
- WATCH_TX_PERIODIC_EN
  - Defined: an internal trigger fires whenever the sec field of i_time differs from its value one cycle earlier.
    - In IDLE the trigger acts like start.
    - In SEND or DONE it sets a single pending flag. The flag starts a new line on the cycle after DONE and clears when that line is accepted. Extra triggers while the flag is already set are dropped.
    - External start keeps working. start and the trigger in the same cycle count as one request.
    - rst clears the pending flag and the previous-sec register.
  - Undefined: only start initiates lines. No edge detector or pending logic is synthesized.

## Structure
- Shared package watch_pkg holds:
  - TIME_W=24 and the field slice positions/widths: HOUR_W=5, MIN_W=6, SEC_W=6, MSEC_W=7
  - LINE_LEN=13
  - ASCII constants: ASCII_0, ASCII_CR, ASCII_LF
  - the state enum tx_state_t {IDLE, SEND, DONE}
- One combinational sub-module, bin2ascii2: 7-bit binary in, saturated to 99, two ASCII digit bytes out. It is instanced per field, or once behind an idx-driven field mux.

## Test plan
- i_time=12:34:56.78, tx_full=0, start → pushes 31 32 3A 33 34 3A 35 36 2E 37 38 0D 0A on 13 consecutive cycles; done exactly once at N+14.
- Same stimulus with tx_full=1 for 5 cycles while idx=3 → no push in those cycles, identical byte sequence, done at N+19.
- i_time changed to 23:59:59.99 in the cycle after start → line still reads "12:34:56.78\r\n".
- start pulsed at N+5 during SEND → ignored, exactly 13 bytes. Separately, msec=7'd120 and hour=0 → "00:…:…  .99" digits, i.e. C1 C0 = 39 39, H1 H0 = 30 30.
- rst asserted after 6 pushes → tx_push=0 and busy=0 from the next cycle, no done. A subsequent start sends the full 13-byte line.
- With WATCH_TX_PERIODIC_EN: sec 5→6 in IDLE → line starts with no start pulse. sec changes twice during SEND → exactly one extra line follows DONE.
